// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB) arbitration logic and the
// wakeup/issue logic that consumes broadcast tags.
//   CDB_TAG_W  : default physical-register tag width
//   cdb_tag_t  : physical-register tag type
//   rr_wrap()  : wraps a scan index that ran past the last source
// -----------------------------------------------------------------------------
package cdb_pkg;

    localparam int CDB_TAG_W = 6;

    typedef logic [CDB_TAG_W-1:0] cdb_tag_t;

    // Used by the round-robin scan, where an index never exceeds 2*n-1, so a
    // single conditional subtract is enough to bring it back into range.
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
// In-order holding buffer for one execution-unit result source. Results that
// lose arbitration wait here until the CDB has a free lane for them.
// Ports:
//   clk, reset   : clock and synchronous active-high reset (empties buffer)
//   flush        : synchronous discard of every buffered tag
//   push         : write push_tag at the tail (ignored when full)
//   push_tag     : tag to be written
//   pop          : remove the head entry (ignored when empty)
//   head         : current oldest tag (only meaningful when !empty)
//   full, empty  : occupancy flags, derived purely from registered state
// Parameters: DEPTH (power of two, >= 2), WIDTH (tag width).
// -----------------------------------------------------------------------------
module cdb_src_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_tag,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer and occupancy bookkeeping. Reset and flush both simply rewind
    // the pointers; the storage itself never needs clearing because an empty
    // buffer's head is never used. A simultaneous push and pop leaves the
    // count unchanged while both pointers advance.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Tag storage, written at the tail whenever a push is accepted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_tag;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Arbitrates completed results from NUM_SRC execution units onto NUM_CDB
// common data bus lanes each cycle. Each source has a small in-order holding
// buffer; when the buffer is empty a fresh result may go straight to the bus
// in the same cycle (bypass). Sources are scanned round-robin starting at
// rr_ptr, and granted results fill lanes 0,1,... in scan order.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   flush             : discards all buffered results and this cycle's results
//   exec_done         : per-source result-valid strobe
//   exec_dest_prf     : per-source destination tag, source i at [i*TAG_W +: TAG_W]
//   exec_ready        : per-source "buffer not full", from registered state
//   cdb_valid         : registered per-lane valid
//   cdb_tag           : registered per-lane tag, lane k at [k*TAG_W +: TAG_W]
//   perf_conflict_cnt : (only with CDB_ARB_PERF_EN) saturating count of cycles
//                       with more candidates than lanes; cleared by reset only
// Optional feature macro: CDB_ARB_PERF_EN
// -----------------------------------------------------------------------------
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int NUM_CDB    = 2,
    parameter int TAG_W      = CDB_TAG_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_SRC-1:0]       exec_done,
    input  logic [NUM_SRC*TAG_W-1:0] exec_dest_prf,
    output logic [NUM_SRC-1:0]       exec_ready,
    output logic [NUM_CDB-1:0]       cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0] cdb_tag
`ifdef CDB_ARB_PERF_EN
    ,
    output logic [31:0]              perf_conflict_cnt
`endif
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         rr_next;

    logic [NUM_SRC-1:0]       fifo_full;
    logic [NUM_SRC-1:0]       fifo_empty;
    logic [TAG_W-1:0]         head     [NUM_SRC];
    logic [TAG_W-1:0]         cand_tag [NUM_SRC];
    logic [NUM_SRC-1:0]       has_cand;
    logic [NUM_SRC-1:0]       accept;
    logic [NUM_SRC-1:0]       grant;
    logic [NUM_SRC-1:0]       push;
    logic [NUM_SRC-1:0]       pop;

    logic [NUM_CDB-1:0]       lane_valid_d;
    logic [NUM_CDB*TAG_W-1:0] lane_tag_d;

    int                       lane_cnt;
    int                       scan_idx;
    int                       last_idx;

    assign exec_ready = ~fifo_full;

    // One holding buffer per source.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (TAG_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .push     (push[i]),
            .push_tag (exec_dest_prf[i*TAG_W +: TAG_W]),
            .pop      (pop[i]),
            .head     (head[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i])
        );
    end

    // Candidate selection per source. A non-empty buffer always offers its
    // head first so per-source order is kept; only an empty buffer lets a
    // fresh result bypass. A result arriving while the buffer is full is a
    // protocol violation and is not accepted. During flush nothing competes.
    always_comb begin
        accept   = '0;
        has_cand = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand_tag[i] = fifo_empty[i] ? exec_dest_prf[i*TAG_W +: TAG_W] : head[i];
            accept[i]   = exec_done[i] & ~fifo_full[i] & ~flush;
            has_cand[i] = ~flush & (~fifo_empty[i] | exec_done[i]);
        end
    end

    // Round-robin grant. Sources are visited starting at rr_ptr with
    // wrap-around; each candidate found takes the next free lane until all
    // lanes are used. The pointer moves just past the last granted source so
    // that source goes to the back of the line next cycle.
    always_comb begin
        grant        = '0;
        lane_valid_d = '0;
        lane_tag_d   = '0;
        lane_cnt     = 0;
        scan_idx     = 0;
        last_idx     = -1;
        for (int off = 0; off < NUM_SRC; off++) begin
            scan_idx = rr_wrap(int'(rr_ptr) + off, NUM_SRC);
            for (int j = 0; j < NUM_SRC; j++) begin
                if ((j == scan_idx) && has_cand[j] && (lane_cnt < NUM_CDB)) begin
                    grant[j] = 1'b1;
                    for (int k = 0; k < NUM_CDB; k++) begin
                        if (k == lane_cnt) begin
                            lane_valid_d[k]               = 1'b1;
                            lane_tag_d[k*TAG_W +: TAG_W] = cand_tag[j];
                        end
                    end
                    lane_cnt = lane_cnt + 1;
                    last_idx = j;
                end
            end
        end
        rr_next = rr_ptr;
        if (last_idx >= 0) begin
            rr_next = PTR_W'(rr_wrap(last_idx + 1, NUM_SRC));
        end
    end

    // Buffer control. A granted head pops; a granted bypass never enters the
    // buffer. Any other accepted result is queued behind whatever is already
    // waiting, even when the head pops in the same cycle.
    always_comb begin
        pop  = '0;
        push = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i]  = grant[i] & ~fifo_empty[i];
            push[i] = accept[i] & ~(grant[i] & fifo_empty[i]);
        end
    end

    // Registered bus outputs and the round-robin pointer. Reset clears the
    // bus and pointer; flush needs no special case here because it removes
    // every candidate, which leaves the bus idle and the pointer untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cdb_valid <= '0;
            cdb_tag   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= lane_valid_d;
            cdb_tag   <= lane_tag_d;
            rr_ptr    <= rr_next;
        end
    end

`ifdef CDB_ARB_PERF_EN
    int   cand_cnt;
    logic conflict;

    // Counts how many sources are competing this cycle to detect lane
    // oversubscription.
    always_comb begin
        cand_cnt = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (has_cand[i]) begin
                cand_cnt = cand_cnt + 1;
            end
        end
        conflict = (cand_cnt > NUM_CDB);
    end

    // Saturating conflict counter; survives flush so it measures whole runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_conflict_cnt <= '0;
        end else if (conflict && (perf_conflict_cnt != '1)) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Self-checking bench for cdb_arbiter with default parameters (4 sources,
// 2 lanes, 6-bit tags, 2-deep buffers). Directed stimulus pushes the
// hand-computed bus output (lane, tag, cycle) into a scoreboard queue; a
// monitor on the falling edge pops and compares every valid lane it sees.
// Extra point checks cover exec_ready, the round-robin pointer, flush and
// reset. Build with CDB_ARB_PERF_EN to also check the conflict counter.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int NUM_CDB = 2;
    localparam int TAG_W   = CDB_TAG_W;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic [NUM_SRC-1:0]       exec_done;
    logic [NUM_SRC*TAG_W-1:0] exec_dest_prf;
    logic [NUM_SRC-1:0]       exec_ready;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
`ifdef CDB_ARB_PERF_EN
    logic [31:0]              perf_conflict_cnt;
`endif

    typedef struct {
        int lane;
        int tag;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   done   = 1'b0;

    cdb_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .NUM_CDB    (NUM_CDB),
        .TAG_W      (TAG_W),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .exec_done     (exec_done),
        .exec_dest_prf (exec_dest_prf),
        .exec_ready    (exec_ready),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag)
`ifdef CDB_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    // Free-running clock and a cycle counter used to time-stamp expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NUM_SRC*TAG_W-1:0] packTags(input int t0, input int t1,
                                                          input int t2, input int t3);
        cdb_tag_t a, b, c, d;
        a = cdb_tag_t'(t0);
        b = cdb_tag_t'(t1);
        c = cdb_tag_t'(t2);
        d = cdb_tag_t'(t3);
        return {d, c, b, a};
    endfunction

    // Expect 'tag' on 'lane' in the cycle right after the next clock edge.
    task automatic expectTag(input int lane, input int tag);
        exp_t e;
        e.lane = lane;
        e.tag  = tag;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, let the edge sample them, then idle inputs.
    task automatic applyStimulus(input logic [NUM_SRC-1:0] d,
                                 input logic [NUM_SRC*TAG_W-1:0] tags,
                                 input logic fl, input logic rst);
        exec_done     = d;
        exec_dest_prf = tags;
        flush         = fl;
        reset         = rst;
        @(posedge clk);
        #1;
        exec_done     = '0;
        exec_dest_prf = '0;
        flush         = 1'b0;
        reset         = 1'b0;
    endtask

    task automatic idle();
        applyStimulus('0, '0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: flags expectations whose cycle has passed, then
    // matches every valid lane against the queue head; idle lanes must be 0.
    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missing_tag: got nothing, expected tag %0d lane %0d in cycle %0d",
                         mon_e.tag, mon_e.lane, mon_e.cyc);
            end
            for (int k = 0; k < NUM_CDB; k++) begin
                checks++;
                if (cdb_valid[k] === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_tag: got tag %0d lane %0d cycle %0d, expected none",
                                 cdb_tag[k*TAG_W +: TAG_W], k, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.lane != k || mon_e.cyc != cyc ||
                            mon_e.tag != int'(cdb_tag[k*TAG_W +: TAG_W])) begin
                            errors++;
                            $display("[TB] FAIL cdb_lane: got tag %0d lane %0d cycle %0d, expected tag %0d lane %0d cycle %0d",
                                     cdb_tag[k*TAG_W +: TAG_W], k, cyc, mon_e.tag, mon_e.lane, mon_e.cyc);
                        end
                    end
                end else if (cdb_valid[k] !== 1'b0 || cdb_tag[k*TAG_W +: TAG_W] !== '0) begin
                    errors++;
                    $display("[TB] FAIL idle_lane: got valid %b tag %0h lane %0d, expected 0/0",
                             cdb_valid[k], cdb_tag[k*TAG_W +: TAG_W], k);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        exec_done     = '0;
        exec_dest_prf = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", 32'(cdb_valid), 32'h0);
        checkOutput("reset_tag", 32'(cdb_tag), 32'h0);
        checkOutput("reset_ready", 32'(exec_ready), 32'hf);
        checkOutput("reset_rr", 32'(dut.rr_ptr), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;

        $display("[TB] single source bypass");
        expectTag(0, 5);
        applyStimulus(4'b0100, packTags(0, 0, 5, 0), 1'b0, 1'b0);
        checkOutput("single_rr", 32'(dut.rr_ptr), 32'd3);
        idle();

        $display("[TB] all sources fire together");
        expectTag(0, 9);
        applyStimulus(4'b1000, packTags(0, 0, 0, 9), 1'b0, 1'b0);
        checkOutput("wrap_rr", 32'(dut.rr_ptr), 32'd0);
        expectTag(0, 1);
        expectTag(1, 2);
        applyStimulus(4'b1111, packTags(1, 2, 3, 4), 1'b0, 1'b0);
        checkOutput("burst_rr_a", 32'(dut.rr_ptr), 32'd2);
        checkOutput("burst_ready", 32'(exec_ready), 32'hf);
        expectTag(0, 3);
        expectTag(1, 4);
        idle();
        checkOutput("burst_rr_b", 32'(dut.rr_ptr), 32'd0);

        $display("[TB] saturation, backpressure and dropped tag");
        expectTag(0, 1);
        expectTag(1, 17);
        applyStimulus(4'b1111, packTags(1, 17, 33, 49), 1'b0, 1'b0);
        expectTag(0, 33);
        expectTag(1, 49);
        applyStimulus(4'b1111, packTags(2, 18, 34, 50), 1'b0, 1'b0);
        expectTag(0, 2);
        expectTag(1, 18);
        applyStimulus(4'b1111, packTags(3, 19, 35, 51), 1'b0, 1'b0);
        checkOutput("sat_ready_a", 32'(exec_ready), 32'b0011);
        expectTag(0, 34);
        expectTag(1, 50);
        applyStimulus(4'b0011, packTags(4, 20, 0, 0), 1'b0, 1'b0);
        checkOutput("sat_ready_b", 32'(exec_ready), 32'b1100);
        expectTag(0, 3);
        expectTag(1, 19);
        applyStimulus(4'b1101, packTags(5, 0, 36, 52), 1'b0, 1'b0);
        checkOutput("sat_ready_c", 32'(exec_ready), 32'b0011);
        expectTag(0, 35);
        expectTag(1, 51);
        idle();
        expectTag(0, 4);
        expectTag(1, 20);
        idle();
        expectTag(0, 36);
        expectTag(1, 52);
        idle();
        checkOutput("sat_rr", 32'(dut.rr_ptr), 32'd0);
        idle();

        $display("[TB] flush with three buffered tags");
        expectTag(0, 6);
        expectTag(1, 21);
        applyStimulus(4'b1111, packTags(6, 21, 37, 53), 1'b0, 1'b0);
        expectTag(0, 37);
        expectTag(1, 53);
        applyStimulus(4'b0111, packTags(7, 22, 38, 0), 1'b0, 1'b0);
        checkOutput("preflush_rr", 32'(dut.rr_ptr), 32'd0);
        applyStimulus(4'b1000, packTags(0, 0, 0, 55), 1'b1, 1'b0);
        checkOutput("flush_valid", 32'(cdb_valid), 32'h0);
        checkOutput("flush_ready", 32'(exec_ready), 32'hf);
        checkOutput("flush_rr", 32'(dut.rr_ptr), 32'd0);
        idle();
        idle();
        expectTag(0, 23);
        applyStimulus(4'b0010, packTags(0, 23, 0, 0), 1'b0, 1'b0);
        checkOutput("postflush_rr", 32'(dut.rr_ptr), 32'd2);

        $display("[TB] reset mid-burst");
        expectTag(0, 39);
        expectTag(1, 56);
        applyStimulus(4'b1111, packTags(8, 24, 39, 56), 1'b0, 1'b0);
        applyStimulus(4'b1111, packTags(9, 25, 40, 57), 1'b0, 1'b1);
        checkOutput("midrst_valid", 32'(cdb_valid), 32'h0);
        checkOutput("midrst_tag", 32'(cdb_tag), 32'h0);
        checkOutput("midrst_ready", 32'(exec_ready), 32'hf);
        checkOutput("midrst_rr", 32'(dut.rr_ptr), 32'd0);
        idle();
        idle();
        expectTag(0, 10);
        applyStimulus(4'b0001, packTags(10, 0, 0, 0), 1'b0, 1'b0);
        checkOutput("postrst_rr", 32'(dut.rr_ptr), 32'd1);
        idle();

`ifdef CDB_ARB_PERF_EN
        $display("[TB] conflict counter");
        applyStimulus('0, '0, 1'b0, 1'b1);
        checkOutput("perf_reset", perf_conflict_cnt, 32'd0);
        for (int n = 0; n < 5; n++) begin
            expectTag(0, 4 * n + 1);
            expectTag(1, 4 * n + 2);
            applyStimulus(4'b1111, packTags(4 * n + 1, 4 * n + 2, 4 * n + 3, 4 * n + 4), 1'b0, 1'b0);
            expectTag(0, 4 * n + 3);
            expectTag(1, 4 * n + 4);
            idle();
        end
        checkOutput("perf_five", perf_conflict_cnt, 32'd5);
        force dut.perf_conflict_cnt = 32'hffff_ffff;
        #1;
        release dut.perf_conflict_cnt;
        expectTag(0, 41);
        expectTag(1, 42);
        applyStimulus(4'b1111, packTags(41, 42, 43, 44), 1'b0, 1'b0);
        expectTag(0, 43);
        expectTag(1, 44);
        idle();
        checkOutput("perf_saturate", perf_conflict_cnt, 32'hffff_ffff);
`endif

        idle();
        idle();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        if (!done) begin
            errors++;
            $display("[TB] FAIL watchdog: got timeout, expected completion");
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

endmodule
